// File: rtl/fb_scan_arbiter.sv
// Framebuffer SRAM arbiter: line prefetch into a double-buffered line buffer,
// full-screen clear sequencing and rasteriser pixel writes on one SRAM port.
//
// state   | meaning
// S_IDLE  | no access in flight; picks fetch > clear > raster write
// S_WRITE | single raster write strobe on the port (or none if off-screen)
// S_FETCH | 20 back-to-back reads of the target line plus one capture cycle
// S_CLEAR | one all-ones-mask zero write per cycle at clr_cnt
module fb_scan_arbiter #(
  parameter int H_PIXELS       = 640,
  parameter int V_LINES        = 480,
  parameter int WORDS_PER_LINE = 20,
  parameter int ADDR_W         = 14
) (
  input  logic              CLOCK_50,
  input  logic              nReset,
  input  logic [9:0]        pixel_x,
  input  logic [8:0]        pixel_y,
  input  logic              blank_n,
  output logic              pixel,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [9:0]        wr_x,
  input  logic [8:0]        wr_y,
  input  logic              wr_pixel,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FETCH, S_CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_LINE * V_LINES - 1);

  function automatic logic [ADDR_W-1:0] line_base(input logic [8:0] y);
    return ADDR_W'({y, 4'b0}) + ADDR_W'({y, 2'b0});
  endfunction

  state_t            state, state_nxt;
  logic              blank_n_q;
  logic [8:0]        pixel_y_q;
  logic              fetch_pending;
  logic [8:0]        fetch_line;
  logic              fetch_bank;
  logic [4:0]        fetch_idx, fetch_idx_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              cap_valid;
  logic [4:0]        cap_idx;
  logic [31:0]       linebuf [2][WORDS_PER_LINE];

  logic [ADDR_W-1:0] mem_addr_nxt;
  logic              mem_re_nxt, mem_we_nxt;
  logic [31:0]       mem_wmask_nxt, mem_wdata_nxt;

  logic              trigger, wr_fire, wr_in_range, clr_done;
  logic [8:0]        tgt_line;

  // pixel_y reads 0 during blanking, so the finished line is taken from the last active cycle
  assign trigger     = blank_n_q && !blank_n;
  assign tgt_line    = (pixel_y_q == 9'(V_LINES - 1)) ? 9'd0 : pixel_y_q + 9'd1;
  assign wr_ready    = (state == S_IDLE) && !fetch_pending && !clr_busy && nReset;
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = (wr_x < 10'(H_PIXELS)) && (wr_y < 9'(V_LINES));
  assign clr_done    = (state == S_CLEAR) && (mem_addr == LAST_ADDR);

  always_comb begin
    state_nxt     = state;
    fetch_idx_nxt = fetch_idx;
    clr_cnt_nxt   = clr_cnt;
    mem_addr_nxt  = '0;
    mem_re_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_wmask_nxt = '0;
    mem_wdata_nxt = '0;
    case (state)
      S_IDLE: begin
        if (fetch_pending) begin
          state_nxt     = S_FETCH;
          fetch_idx_nxt = '0;
          mem_re_nxt    = 1'b1;
          mem_addr_nxt  = line_base(fetch_line);
        end else if (clr_busy) begin
          state_nxt     = S_CLEAR;
          mem_we_nxt    = 1'b1;
          mem_wmask_nxt = '1;
          mem_addr_nxt  = clr_cnt;
          clr_cnt_nxt   = clr_cnt + ADDR_W'(1);
        end else if (wr_fire) begin
          state_nxt     = S_WRITE;
          mem_we_nxt    = wr_in_range;
          mem_addr_nxt  = line_base(wr_y) + ADDR_W'(wr_x[9:5]);
          mem_wmask_nxt = 32'd1 << wr_x[4:0];
          mem_wdata_nxt = {32{wr_pixel}};
        end
      end
      S_WRITE: state_nxt = S_IDLE;
      S_FETCH: begin
        if (fetch_idx == 5'(WORDS_PER_LINE)) begin
          state_nxt = S_IDLE;
        end else begin
          fetch_idx_nxt = fetch_idx + 5'd1;
          if (fetch_idx < 5'(WORDS_PER_LINE - 1)) begin
            mem_re_nxt   = 1'b1;
            mem_addr_nxt = mem_addr + ADDR_W'(1);
          end
        end
      end
      S_CLEAR: begin
        if (clr_done) begin
          state_nxt   = S_IDLE;
          clr_cnt_nxt = '0;
        end else if (fetch_pending) begin
          state_nxt = S_IDLE;
        end else begin
          mem_we_nxt    = 1'b1;
          mem_wmask_nxt = '1;
          mem_addr_nxt  = clr_cnt;
          clr_cnt_nxt   = clr_cnt + ADDR_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      state         <= S_IDLE;
      blank_n_q     <= 1'b0;
      pixel_y_q     <= '0;
      fetch_pending <= 1'b0;
      fetch_line    <= '0;
      fetch_bank    <= 1'b0;
      fetch_idx     <= '0;
      clr_cnt       <= '0;
      clr_busy      <= 1'b0;
      cap_valid     <= 1'b0;
      cap_idx       <= '0;
      mem_addr      <= '0;
      mem_re        <= 1'b0;
      mem_we        <= 1'b0;
      mem_wmask     <= '0;
      mem_wdata     <= '0;
    end else begin
      state     <= state_nxt;
      blank_n_q <= blank_n;
      if (blank_n) pixel_y_q <= pixel_y;
      // a trigger landing on the FETCH entry edge stays latched for the next pass
      if (trigger) begin
        fetch_pending <= 1'b1;
        fetch_line    <= tgt_line;
      end else if (state == S_IDLE && fetch_pending) begin
        fetch_pending <= 1'b0;
      end
      if (state == S_IDLE && fetch_pending) fetch_bank <= fetch_line[0];
      fetch_idx <= fetch_idx_nxt;
      clr_cnt   <= clr_cnt_nxt;
      if (clr_done)     clr_busy <= 1'b0;
      else if (clr_req) clr_busy <= 1'b1;
      cap_valid <= mem_re;
      cap_idx   <= fetch_idx;
      mem_addr  <= mem_addr_nxt;
      mem_re    <= mem_re_nxt;
      mem_we    <= mem_we_nxt;
      mem_wmask <= mem_wmask_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      pixel <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int w = 0; w < WORDS_PER_LINE; w++)
          linebuf[b][w] <= '0;
    end else begin
      if (cap_valid) linebuf[fetch_bank][cap_idx] <= mem_rdata;
      if (blank_n && pixel_x[9:5] < 5'(WORDS_PER_LINE))
        pixel <= linebuf[pixel_y[0]][pixel_x[9:5]][pixel_x[4:0]];
      else
        pixel <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Directed bench for fb_scan_arbiter: behavioural sync SRAM, access logging
// monitor and hand-computed expectations for writes, fetches, wrap and clear.
module tb_fb_scan_arbiter;

  logic        clk;
  logic        nReset;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic        blank_n;
  logic        pixel;
  logic        wr_valid, wr_ready;
  logic [9:0]  wr_x;
  logic [8:0]  wr_y;
  logic        wr_pixel;
  logic        clr_req, clr_busy;
  logic [13:0] mem_addr;
  logic        mem_re, mem_we;
  logic [31:0] mem_wmask, mem_wdata, mem_rdata;

  fb_scan_arbiter dut (
    .CLOCK_50(clk), .nReset(nReset),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .blank_n(blank_n), .pixel(pixel),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(wr_pixel),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  logic [31:0] sram [9600];
  int cyc = 0;
  int both_err = 0;
  int rd_addr_q[$], rd_cyc_q[$], wr_addr_q[$], wr_cyc_q[$];
  bit rd_rdy_q[$], wr_clr_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!nReset) begin
      for (int i = 0; i < 9600; i++) sram[i] <= 32'h0;
      sram[0]   <= 32'h0000_0001;
      sram[19]  <= 32'h8000_0000;
      sram[121] <= 32'h0000_0002;
      mem_rdata <= 32'h0;
    end else begin
      if (mem_re) mem_rdata <= sram[mem_addr];
      if (mem_we) sram[mem_addr] <= (sram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
    end
  end

  always @(negedge clk) begin
    if (nReset) begin
      if (mem_re) begin
        rd_addr_q.push_back(int'(mem_addr));
        rd_cyc_q.push_back(cyc);
        rd_rdy_q.push_back(wr_ready);
      end
      if (mem_we) begin
        wr_addr_q.push_back(int'(mem_addr));
        wr_cyc_q.push_back(cyc);
        wr_clr_q.push_back(mem_wmask == 32'hFFFF_FFFF && mem_wdata == 32'h0);
      end
      if (mem_re && mem_we) both_err <= both_err + 1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) $display("FAIL %s got=%0h want=%0h", tag, got, want);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // checks the 20 reads logged from index base onward
  task automatic chk_fetch(input string tag, input int base, input int first_addr);
    int n, bad, rdy;
    n = rd_addr_q.size() - base;
    bad = 0;
    rdy = 0;
    chk({tag, "_count"}, n, 20);
    if (n >= 20) begin
      for (int i = 0; i < 20; i++) begin
        if (rd_addr_q[base + i] != first_addr + i) bad++;
        if (rd_rdy_q[base + i]) rdy++;
      end
      chk({tag, "_addr_err"}, bad, 0);
      chk({tag, "_b2b_span"}, rd_cyc_q[base + 19] - rd_cyc_q[base], 19);
      chk({tag, "_ready_seen"}, rdy, 0);
    end
  endtask

  int rd_base, wr_base, n, bad, fmt_bad, pre, post, first_rd, last_rd;
  bit trig_done;

  initial begin
    nReset = 1'b0; pixel_x = '0; pixel_y = '0; blank_n = 1'b0;
    wr_valid = 1'b1; wr_x = 10'd37; wr_y = 9'd2; wr_pixel = 1'b1; clr_req = 1'b0;
    ticks(3);
    chk("rst_pixel", pixel, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_clr_busy", clr_busy, 0);
    nReset = 1'b1;
    #1;
    chk("rel_wr_ready", wr_ready, 1);

    tick();
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 41);
    chk("wr_mask", mem_wmask, 32'h0000_0020);
    chk("wr_data", mem_wdata, 32'hFFFF_FFFF);
    wr_x = 10'd640;
    tick();
    chk("wr_idle_ready", wr_ready, 1);
    tick();
    chk("wr_oob_we", mem_we, 0);
    chk("wr_oob_accepted", wr_ready, 0);
    wr_valid = 1'b0;
    tick();
    chk("wr_sram41", sram[41], 32'h0000_0020);

    // fetch of line 6 at the end of line 5
    pixel_y = 9'd5; blank_n = 1'b1;
    tick();
    rd_base = rd_addr_q.size();
    blank_n = 1'b0;
    ticks(30);
    chk_fetch("fetch6", rd_base, 120);
    pixel_y = 9'd6; pixel_x = 10'd33; blank_n = 1'b1;
    tick();
    chk("pix_l6_x33", pixel, 1);
    pixel_x = 10'd32;
    tick();
    chk("pix_l6_x32", pixel, 0);
    blank_n = 1'b0;
    ticks(30);

    // wrap from the last line to line 0; pixel_y already 0 in blanking
    pixel_y = 9'd479; blank_n = 1'b1;
    tick();
    rd_base = rd_addr_q.size();
    blank_n = 1'b0; pixel_y = 9'd0;
    ticks(30);
    chk_fetch("wrap", rd_base, 0);
    pixel_y = 9'd0; pixel_x = 10'd0; blank_n = 1'b1;
    tick();
    chk("pix_l0_x0", pixel, 1);
    pixel_x = 10'd639;
    tick();
    chk("pix_l0_x639", pixel, 1);
    pixel_x = 10'd33;
    tick();
    chk("pix_l0_x33", pixel, 0);
    blank_n = 1'b0;
    tick();
    chk("pix_blank", pixel, 0);
    ticks(30);

    // full clear with a line fetch injected after 500 writes
    pixel_y = 9'd9; blank_n = 1'b1;
    wr_base = wr_addr_q.size();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("clr_busy_set", clr_busy, 1);
    trig_done = 1'b0;
    for (int i = 0; i < 12000 && clr_busy; i++) begin
      clr_req = (i == 100);
      if (!trig_done && wr_addr_q.size() - wr_base >= 500) begin
        rd_base = rd_addr_q.size();
        blank_n = 1'b0;
        trig_done = 1'b1;
      end
      tick();
    end
    clr_req = 1'b0;
    chk("clr_busy_done", clr_busy, 0);
    n = wr_addr_q.size() - wr_base;
    chk("clr_write_count", n, 9600);
    bad = 0;
    fmt_bad = 0;
    for (int i = 0; i < n; i++) begin
      if (wr_addr_q[wr_base + i] != i) bad++;
      if (!wr_clr_q[wr_base + i]) fmt_bad++;
    end
    chk("clr_seq_err", bad, 0);
    chk("clr_fmt_err", fmt_bad, 0);
    if (n > 0) chk("clr_last_addr", wr_addr_q[wr_base + n - 1], 9599);
    chk_fetch("clr_fetch", rd_base, 200);
    if (n > 0 && rd_addr_q.size() > rd_base)
      chk("clr_paused", (rd_cyc_q[rd_base] > wr_cyc_q[wr_base]) &&
                        (rd_cyc_q[rd_base] < wr_cyc_q[wr_base + n - 1]), 1);
    chk("clr_sram41", sram[41], 0);

    // raster write held high across the fetch trigger
    pixel_y = 9'd20; blank_n = 1'b1;
    tick();
    rd_base = rd_addr_q.size();
    wr_base = wr_addr_q.size();
    blank_n = 1'b0;
    wr_valid = 1'b1; wr_x = 10'd5; wr_y = 9'd100; wr_pixel = 1'b1;
    ticks(40);
    wr_valid = 1'b0;
    tick();
    chk_fetch("coll", rd_base, 420);
    pre = 0;
    post = 0;
    if (rd_addr_q.size() - rd_base >= 20) begin
      first_rd = rd_cyc_q[rd_base];
      last_rd  = rd_cyc_q[rd_base + 19];
      for (int i = wr_base; i < wr_addr_q.size(); i++) begin
        if (wr_cyc_q[i] < first_rd) pre++;
        if (wr_cyc_q[i] > last_rd) post++;
      end
    end
    chk("coll_pre_le1", pre <= 1, 1);
    chk("coll_post_write", post > 0, 1);
    chk("re_we_overlap", both_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fb_scan_arbiter.md
Name: fb_scan_arbiter

Overview:
- Shares one single-port synchronous framebuffer SRAM (1 bpp, 640x480, packed into 32-bit words) between two users:
  - the VGA scan-out path, which consumes pixel_x/pixel_y/VGA_BLANK_N from the timing generator and returns pixel;
  - the software rasteriser pixel-write port.
- Prefetches each display line into a double-buffered line buffer during horizontal blanking.
- Also sequences a full-screen clear command.
- Fixed priority: line fetch > clear > raster write.

Parameters:
- H_PIXELS, 640, active pixels per line.
- V_LINES, 480, active lines per frame.
- WORDS_PER_LINE, 20, H_PIXELS/32.
- ADDR_W, 14, SRAM word address width (9600 words).

Ports:
- CLOCK_50  in  1  system clock.
- nReset  in  1  reset; asynchronous, active-low.
- pixel_x  in  10  scan-out column; 0 outside active area.
- pixel_y  in  9  scan-out line; 0 outside active area.
- blank_n  in  1  VGA_BLANK_N; high in active area.
- pixel  out  1  registered pixel for (pixel_x, pixel_y).
- wr_valid  in  1  rasteriser write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_x  in  10  write column.
- wr_y  in  9  write line.
- wr_pixel  in  1  write value.
- clr_req  in  1  single-cycle clear request.
- clr_busy  out  1  clear in progress.
- mem_addr  out  ADDR_W  SRAM word address (registered).
- mem_re  out  1  SRAM read strobe (registered).
- mem_we  out  1  SRAM write strobe (registered).
- mem_wmask  out  32  per-bit write enable (registered).
- mem_wdata  out  32  write data (registered).
- mem_rdata  in  32  read data, valid one cycle after mem_re.

Behaviour:
- Reset:
  - All outputs are 0 and the FSM is in IDLE.
  - Line buffers (2 x 20 x 32 bits) are cleared to 0.
  - fetch_pending and the clear counter are cleared.
  - Reset mid-fetch or mid-clear abandons the operation; no further mem strobes are issued.
- Word address: addr(x,y) = y*20 + x[9:5]. Compute y*20 as (y<<4)+(y<<2), ADDR_W bits wide. Bit index within the word is x[4:0].
- Fetch trigger:
  - Registered blank_n_q; trigger when blank_n_q=1 and blank_n=0 (end of active line y = pixel_y).
  - Target line t = (y == V_LINES-1) ? 0 : y+1. Target bank = t[0].
  - Sets fetch_pending at the cycle end.
  - A trigger while pending or while in FETCH is latched once; it is serviced after the current fetch.
- FSM states: IDLE, WRITE, FETCH, CLEAR.
  - IDLE: if fetch_pending -> FETCH; else if clear active -> CLEAR; else if raster handshake -> WRITE.
  - WRITE (1 cycle):
    - Drives mem_we=1, mem_addr=addr(wr_x,wr_y), mem_wmask=1<<wr_x[4:0], mem_wdata={32{wr_pixel}}.
    - If wr_x>=H_PIXELS or wr_y>=V_LINES, the request is still accepted but mem_we stays 0.
    - Returns to IDLE.
  - FETCH:
    - Issues mem_re on 20 consecutive cycles, addresses t*20 .. t*20+19.
    - mem_rdata is captured one cycle after each read into linebuf[bank][i].
    - Clears fetch_pending on entry; returns to IDLE after the last capture (21 cycles).
    - Not interruptible.
  - CLEAR:
    - Each cycle: mem_we=1, mem_wmask=32'hFFFFFFFF, mem_wdata=0, mem_addr=clr_cnt; clr_cnt increments.
    - If fetch_pending rises, finishes the current cycle, goes to IDLE, then FETCH; resumes at the held clr_cnt with no skipped or duplicated address.
    - Completes after address 9599: clr_busy drops the next cycle and clr_cnt resets to 0.
- Clear start: clr_req sets clr_busy the next cycle. clr_req while clr_busy=1 is ignored.
- wr_ready = (state==IDLE) && !fetch_pending && !clr_busy && nReset. At most one write per 2 cycles.
- Memory port: exactly one of mem_re/mem_we is active per cycle, or neither. All mem outputs are registered from FSM state.
- Scan-out: pixel <= blank_n ? linebuf[pixel_y[0]][pixel_x[9:5]][pixel_x[4:0]] : 0, one cycle latency. The timing generator holds each pixel for 2 CLOCK_50 cycles, so the latency is invisible.
- Timing budget: hblank = 320 CLOCK_50 cycles, against 21 cycles per fetch plus at most 1 pending write cycle.
- Display coherence: raster writes to the line currently displayed become visible only on the next frame's fetch.

Test Plan:
- Reset: hold nReset=0 with wr_valid=1 -> pixel, mem_re, mem_we, mem_addr, wr_ready, clr_busy all 0. First cycle after release: wr_ready=1.
- Write: x=37, y=2, pixel=1 -> next cycle mem_we=1, mem_addr=41, mem_wmask=32'h00000020, mem_wdata=32'hFFFFFFFF. Then x=640 -> accepted, no mem_we.
- Fetch: blank_n falls with pixel_y=5 -> 20 reads at addr 120..139, wr_ready=0 throughout. With word 121 = 32'h2 on line 6, pixel_x=33 -> pixel=1 one cycle later.
- Wrap: blank_n falls with pixel_y=479 -> reads 0..19 into bank 0. Line 0 at pixel_x=0 shows word0 bit0.
- Clear: clr_req -> 9600 writes, addrs 0..9599, mask all-ones, data 0. Fetch trigger injected when clr_cnt=500 -> clear pauses, 20 reads run, clear resumes at 500, total writes still 9600, clr_busy then 0.
- Collision: wr_valid held high as blank_n falls -> at most one write issued before the first read. All 20 reads are back-to-back. The write completes after the fetch ends.
